// File: rtl/lelo_temp_seq.sv
// lelo_temp_seq: ring-oscillator temperature sensor measurement sequencer.
// Powers the sensor, waits SETTLE_CYC cycles, counts synchronised osc_in rising
// edges over WINDOW_CYC cycles and presents the count on a valid/ready port.
// Ports: clk, rst_n (sync, active-low), start/cont (requests), osc_in (async
// sensor oscillator), sens_en (sensor enable), busy, res_data/res_ovf/res_valid
// (result), res_ready (consumer accept).
module lelo_temp_seq #(
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1000,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             osc_in,
  output logic             sens_en,
  output logic             busy,
  output logic [CNT_W-1:0] res_data,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_t;
  localparam logic [15:0] SET_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] WIN_LD = 16'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_t state, state_nxt;
  logic [15:0] timer;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic ovf_nxt, s1, s2, prev, osc_rise;
  assign osc_rise = s2 & ~prev;
  always_comb begin
    cnt_nxt = (osc_rise && cnt != CMAX) ? cnt + CNT_W'(1) : cnt;
    // overflow means an edge arrived with no room left to count it
    ovf_nxt = res_ovf | (osc_rise && cnt == CMAX);
    state_nxt = (state == IDLE)   ? ((start | cont) ? SETTLE : IDLE) :
                (state == SETTLE) ? ((timer == 16'd0) ? COUNT : SETTLE) :
                (state == COUNT)  ? ((timer == 16'd0) ? HOLD : COUNT) :
                (res_ready ? (cont ? SETTLE : IDLE) : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      prev      <= 1'b0;
      sens_en   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
    end else begin
      s1        <= osc_in;
      s2        <= s1;
      prev      <= s2;
      state     <= state_nxt;
      // outputs are registered from the next state so they align with it
      sens_en   <= (state_nxt == SETTLE) || (state_nxt == COUNT);
      busy      <= state_nxt != IDLE;
      res_valid <= state_nxt == HOLD;
      timer     <= (state != SETTLE && state_nxt == SETTLE) ? SET_LD :
                   (state == SETTLE && state_nxt == COUNT)  ? WIN_LD :
                   (timer != 16'd0) ? timer - 16'd1 : timer;
      if (state == SETTLE && state_nxt == COUNT) begin
        cnt     <= '0;
        res_ovf <= 1'b0;
      end else if (state == COUNT) begin
        cnt     <= cnt_nxt;
        res_ovf <= ovf_nxt;
        if (state_nxt == HOLD) res_data <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_lelo_temp_seq.sv
// tb_lelo_temp_seq: directed scoreboard bench for lelo_temp_seq.
module tb_lelo_temp_seq;
  localparam int S = 4;
  localparam int W = 100;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic osc_in;
  logic res_ready = 1'b1;
  logic sens_en, busy, res_ovf, res_valid;
  logic [CW-1:0] res_data;
  int cyc = 0;
  int osc_half = 1;
  int ntests = 0;
  int nfail = 0;
  int sb[$];
  lelo_temp_seq #(.SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .osc_in(osc_in),
    .sens_en(sens_en), .busy(busy), .res_data(res_data), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb osc_in = (osc_half == 0) ? 1'b0 : ((cyc / osc_half) % 2 == 1);
  function automatic bit xf(int c);
    return (osc_half == 0) ? 1'b0 : ((c / osc_half) % 2 == 1);
  endfunction
  // expected {ovf,data} for a measurement whose request was sampled in cycle t0;
  // an edge is seen by the counter two cycles after it appears on osc_in
  function automatic int model(int t0);
    int n = 0;
    for (int c = t0 + S + 1; c <= t0 + S + W; c++)
      if (xf(c - 2) && !xf(c - 3)) n++;
    return (n > MAXC) ? (MAXC | 256) : n;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic get_result(string tag, int exp_cyc);
    int n = 0;
    int e;
    @(negedge clk);
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(res_valid), 1);
    if (res_valid !== 1'b1) return;
    chk({tag, "_cycle"}, cyc, exp_cyc);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_data"}, 32'(res_data), e & 255);
    chk({tag, "_ovf"}, 32'(res_ovf), (e >> 8) & 1);
  endtask
  task automatic single_shot(string tag);
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    sb.push_back(model(t0));
    chk({tag, "_sens_en_c0"}, 32'(sens_en), 0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_sens_en_c1"}, 32'(sens_en), 1);
    chk({tag, "_busy_c1"}, 32'(busy), 1);
    repeat (S + W - 1) @(negedge clk);
    chk({tag, "_sens_en_last"}, 32'(sens_en), 1);
    chk({tag, "_valid_early"}, 32'(res_valid), 0);
    get_result(tag, t0 + 1 + S + W);
    chk({tag, "_sens_en_hold"}, 32'(sens_en), 0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(res_valid), 0);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
  endtask
  initial begin
    int t0;
    logic [CW-1:0] d0;
    logic o0;
    bit seen;
    // reset with start and oscillator active
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {27'd0, sens_en, busy, res_valid, res_ovf, 1'b0}, 0);
      chk("rst_data", 32'(res_data), 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_sens", 32'(sens_en), 0);
    // single shot, osc period 10
    osc_half = 5;
    single_shot("single");
    // saturation with fast osc, then a clean measurement
    osc_half = 1;
    single_shot("sat");
    osc_half = 5;
    single_shot("after_sat");
    // backpressure
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    sb.push_back(model(t0));
    @(negedge clk);
    start = 1'b0;
    get_result("bp", t0 + 1 + S + W);
    d0 = res_data;
    o0 = res_ovf;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 10);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_data", 32'(res_data), 32'(d0));
      chk("bp_ovf", 32'(res_ovf), 32'(o0));
      chk("bp_sens_en", 32'(sens_en), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(res_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);
    @(negedge clk);
    chk("bp_stays_idle", 32'(busy), 0);
    // continuous mode: three results, cont dropped mid-COUNT of the third
    @(negedge clk);
    cont = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) sb.push_back(model(t0 + k * (S + W + 1)));
    get_result("cont0", t0 + 1 + S + W);
    get_result("cont1", t0 + 2 * (S + W + 1));
    repeat (S + 50) @(negedge clk);
    cont = 1'b0;
    get_result("cont2", t0 + 3 * (S + W + 1));
    @(negedge clk);
    chk("cont_end_valid", 32'(res_valid), 0);
    chk("cont_end_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    chk("cont_stays_idle", 32'(busy), 0);
    // reset mid-COUNT aborts without a result
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_sens_en", 32'(sens_en), 0);
    chk("abort_busy", 32'(busy), 0);
    seen = 1'b0;
    repeat (W + 10) begin
      @(negedge clk);
      seen |= (res_valid !== 1'b0) || (busy !== 1'b0);
    end
    chk("abort_no_result", 32'(seen), 0);
    single_shot("after_abort");
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
